dispatcher_sequencer: RTL and testbench

Job-level controller that sequences one DISPATCHER instance.
- Accepts a job descriptor: iteration count, activation reads per iteration, and weight base address.
- Pulses the dispatcher configure inputs, fetches one weight per iteration from the weight buffer, and presents each weight on the dispatcher weight handshake.
- Monitors the activation handshake and signals job completion.
- Sits between the layer control FSM, the weight buffer and the dispatcher.

---
 rtl/dispatcher_pkg.sv | 23 ++
 rtl/seq_weight_stage.sv | 41 ++++
 rtl/dispatcher_sequencer.sv | 175 +++++++++++++++++
 tb/tb_dispatcher_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dispatcher_pkg.sv
// Shared constants and FSM encoding for the dispatcher job sequencer.
package dispatcher_pkg;

  localparam int unsigned DATA_WIDTH             = 8;
  localparam int unsigned GROUP_SIZE             = 4;
  localparam int unsigned LOG_MAX_ITERS          = 16;
  localparam int unsigned LOG_MAX_READS_PER_ITER = 16;
  localparam int unsigned WADDR_WIDTH            = 10;

  // Width of iters * reads; wide enough that the job total never overflows.
  localparam int unsigned PROD_WIDTH = LOG_MAX_ITERS + LOG_MAX_READS_PER_ITER;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StConfig  = 3'd1,
    StFetch   = 3'd2,
    StLoad    = 3'd3,
    StPresent = 3'd4,
    StDrain   = 3'd5,
    StDone    = 3'd6
  } seq_state_e;

endpackage

// File: rtl/seq_weight_stage.sv
// Weight output register: captures the weight buffer read data, holds it valid
// until the dispatcher takes it, and drops it on a flush.
module seq_weight_stage
  import dispatcher_pkg::*;
#(
  parameter int unsigned Width = DATA_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             flush_i,
  input  logic [Width-1:0] data_i,
  input  logic             avail_i,
  output logic [Width-1:0] data_o,
  output logic             valid_o,
  output logic             xfer_o
);

  logic [Width-1:0] data_q;
  logic             valid_q;

  // Flush beats load beats handshake completion; data only changes on load.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      data_q  <= data_i;
      valid_q <= 1'b1;
    end else if (valid_q && avail_i) begin
      valid_q <= 1'b0;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign xfer_o  = valid_q && avail_i;

endmodule

// File: rtl/dispatcher_sequencer.sv
// Job-level sequencer for one dispatcher: latches a job descriptor, configures
// the dispatcher, feeds it one weight per iteration and watches activation
// traffic to decide when the job is complete.
// Optional: define DISPATCHER_SEQ_PERF_EN to add weight-stall and job-cycle
// performance counters (perf_wstall_out, perf_job_cycles_out).
module dispatcher_sequencer #(
  parameter int unsigned DATA_WIDTH             = dispatcher_pkg::DATA_WIDTH,
  parameter int unsigned LOG_MAX_ITERS          = dispatcher_pkg::LOG_MAX_ITERS,
  parameter int unsigned LOG_MAX_READS_PER_ITER = dispatcher_pkg::LOG_MAX_READS_PER_ITER,
  parameter int unsigned WADDR_WIDTH            = dispatcher_pkg::WADDR_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              job_valid_in,
  output logic                              job_avail_out,
  input  logic [LOG_MAX_ITERS-1:0]          job_num_iters_in,
  input  logic [LOG_MAX_READS_PER_ITER-1:0] job_num_reads_in,
  input  logic [WADDR_WIDTH-1:0]            job_wbase_in,
  input  logic                              abort_in,
  output logic                              disp_configure_out,
  output logic [LOG_MAX_ITERS-1:0]          disp_num_iters_out,
  output logic [LOG_MAX_READS_PER_ITER-1:0] disp_num_reads_per_iter_out,
  output logic                              wmem_rd_out,
  output logic [WADDR_WIDTH-1:0]            wmem_addr_out,
  input  logic [DATA_WIDTH-1:0]             wmem_data_in,
  output logic [DATA_WIDTH-1:0]             weight_data_out,
  output logic                              weight_valid_out,
  input  logic                              weight_avail_in,
  input  logic                              act_valid_mon_in,
  input  logic                              act_avail_mon_in,
  output logic                              done_out,
  output logic                              err_out
`ifdef DISPATCHER_SEQ_PERF_EN
  ,
  output logic [31:0]                       perf_wstall_out,
  output logic [31:0]                       perf_job_cycles_out
`endif
);

  import dispatcher_pkg::*;

  localparam int unsigned ProdWidth = LOG_MAX_ITERS + LOG_MAX_READS_PER_ITER;

  seq_state_e state_q, state_d;

  logic [LOG_MAX_ITERS-1:0]          num_iters_q, iter_cnt_q, iter_cnt_inc;
  logic [LOG_MAX_READS_PER_ITER-1:0] num_reads_q;
  logic [WADDR_WIDTH-1:0]            wbase_q;
  logic [ProdWidth-1:0]              total_q, act_cnt_q, act_cnt_inc;
  logic                              err_q;

  logic accept, zero_job, act_xfer, act_done, last_iter, w_xfer, abort_act;

  assign accept       = (state_q == StIdle) && job_valid_in;
  assign zero_job     = (job_num_iters_in == '0) || (job_num_reads_in == '0);
  // Activation traffic outside a job belongs to nobody and is not counted.
  assign act_xfer     = act_valid_mon_in && act_avail_mon_in && (state_q != StIdle);
  assign act_cnt_inc  = act_cnt_q + ProdWidth'(act_xfer);
  // Looks at the post-increment count so a transfer this cycle is included.
  assign act_done     = (act_cnt_inc == total_q);
  assign iter_cnt_inc = iter_cnt_q + LOG_MAX_ITERS'(1);
  assign last_iter    = (iter_cnt_inc == num_iters_q);
  assign abort_act    = abort_in && (state_q != StIdle);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort overrides every non-idle transition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (job_valid_in) state_d = zero_job ? StDone : StConfig;
      StConfig:  state_d = StFetch;
      StFetch:   state_d = StLoad;
      StLoad:    state_d = StPresent;
      StPresent: begin
        if (w_xfer) begin
          if (last_iter) state_d = act_done ? StDone : StDrain;
          else           state_d = StFetch;
        end
      end
      StDrain:   if (act_done) state_d = StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
    if (abort_act) state_d = StIdle;
  end

  // Job descriptor and error flag, captured on accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      num_iters_q <= '0;
      num_reads_q <= '0;
      wbase_q     <= '0;
      total_q     <= '0;
      err_q       <= 1'b0;
    end else if (accept) begin
      num_iters_q <= job_num_iters_in;
      num_reads_q <= job_num_reads_in;
      wbase_q     <= job_wbase_in;
      total_q     <= ProdWidth'(job_num_iters_in) * ProdWidth'(job_num_reads_in);
      err_q       <= zero_job;
    end
  end

  // Iteration and activation counters, cleared on accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iter_cnt_q <= '0;
      act_cnt_q  <= '0;
    end else if (accept) begin
      iter_cnt_q <= '0;
      act_cnt_q  <= '0;
    end else begin
      if ((state_q == StPresent) && w_xfer) iter_cnt_q <= iter_cnt_inc;
      if (act_xfer)                         act_cnt_q  <= act_cnt_inc;
    end
  end

  seq_weight_stage #(
    .Width(DATA_WIDTH)
  ) u_weight_stage (
    .clk_i   (clk),
    .rst_ni  (rst),
    .load_i  (state_q == StLoad),
    .flush_i (abort_act),
    .data_i  (wmem_data_in),
    .avail_i (weight_avail_in),
    .data_o  (weight_data_out),
    .valid_o (weight_valid_out),
    .xfer_o  (w_xfer)
  );

  assign job_avail_out               = (state_q == StIdle);
  assign disp_configure_out          = (state_q == StConfig);
  assign disp_num_iters_out          = num_iters_q;
  assign disp_num_reads_per_iter_out = num_reads_q;
  assign wmem_rd_out                 = (state_q == StFetch);
  // Address wraps silently at the buffer size.
  assign wmem_addr_out = wmem_rd_out ? (wbase_q + WADDR_WIDTH'(iter_cnt_q)) : '0;
  assign done_out                    = (state_q == StDone);
  assign err_out                     = err_q;

`ifdef DISPATCHER_SEQ_PERF_EN
  logic [31:0] perf_wstall_q, perf_cycles_q;

  // Saturating stall and busy-cycle counters; they stop on their own once idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_wstall_q <= '0;
      perf_cycles_q <= '0;
    end else if (accept) begin
      perf_wstall_q <= '0;
      perf_cycles_q <= '0;
    end else begin
      if (weight_valid_out && !weight_avail_in && (perf_wstall_q != '1)) begin
        perf_wstall_q <= perf_wstall_q + 32'd1;
      end
      if ((state_q != StIdle) && (perf_cycles_q != '1)) begin
        perf_cycles_q <= perf_cycles_q + 32'd1;
      end
    end
  end

  assign perf_wstall_out     = perf_wstall_q;
  assign perf_job_cycles_out = perf_cycles_q;
`endif

endmodule

// File: tb/tb_dispatcher_sequencer.sv
// Self-checking bench for dispatcher_sequencer: directed jobs from the test
// plan followed by randomized jobs, all checked against a transaction-level
// model (expected weights, read addresses and the completion point).
module tb_dispatcher_sequencer;

  localparam int unsigned DW       = 8;
  localparam int unsigned LI       = 16;
  localparam int unsigned LR       = 16;
  localparam int unsigned AW       = 10;
  localparam int unsigned MemWords = 1 << AW;
  localparam int          Budget   = 600;

  logic          clk = 1'b0;
  logic          rst;
  logic          job_valid_in;
  logic          job_avail_out;
  logic [LI-1:0] job_num_iters_in;
  logic [LR-1:0] job_num_reads_in;
  logic [AW-1:0] job_wbase_in;
  logic          abort_in;
  logic          disp_configure_out;
  logic [LI-1:0] disp_num_iters_out;
  logic [LR-1:0] disp_num_reads_per_iter_out;
  logic          wmem_rd_out;
  logic [AW-1:0] wmem_addr_out;
  logic [DW-1:0] wmem_data_in;
  logic [DW-1:0] weight_data_out;
  logic          weight_valid_out;
  logic          weight_avail_in;
  logic          act_valid_mon_in;
  logic          act_avail_mon_in;
  logic          done_out;
  logic          err_out;
`ifdef DISPATCHER_SEQ_PERF_EN
  logic [31:0]   perf_wstall_out;
  logic [31:0]   perf_job_cycles_out;
`endif

  always #5 clk = ~clk;

  dispatcher_sequencer #(
    .DATA_WIDTH            (DW),
    .LOG_MAX_ITERS         (LI),
    .LOG_MAX_READS_PER_ITER(LR),
    .WADDR_WIDTH           (AW)
  ) dut (
    .clk                        (clk),
    .rst                        (rst),
    .job_valid_in               (job_valid_in),
    .job_avail_out              (job_avail_out),
    .job_num_iters_in           (job_num_iters_in),
    .job_num_reads_in           (job_num_reads_in),
    .job_wbase_in               (job_wbase_in),
    .abort_in                   (abort_in),
    .disp_configure_out         (disp_configure_out),
    .disp_num_iters_out         (disp_num_iters_out),
    .disp_num_reads_per_iter_out(disp_num_reads_per_iter_out),
    .wmem_rd_out                (wmem_rd_out),
    .wmem_addr_out              (wmem_addr_out),
    .wmem_data_in               (wmem_data_in),
    .weight_data_out            (weight_data_out),
    .weight_valid_out           (weight_valid_out),
    .weight_avail_in            (weight_avail_in),
    .act_valid_mon_in           (act_valid_mon_in),
    .act_avail_mon_in           (act_avail_mon_in),
    .done_out                   (done_out),
    .err_out                    (err_out)
`ifdef DISPATCHER_SEQ_PERF_EN
    ,
    .perf_wstall_out            (perf_wstall_out),
    .perf_job_cycles_out        (perf_job_cycles_out)
`endif
  );

  logic [DW-1:0] mem [MemWords];
  int n_cmp = 0;
  int n_bad = 0;
  int exp_wstall;
  int exp_cycles;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_avail"}, job_avail_out, 1);
    check({tag, "_cfg"}, disp_configure_out, 0);
    check({tag, "_iters"}, disp_num_iters_out, 0);
    check({tag, "_reads"}, disp_num_reads_per_iter_out, 0);
    check({tag, "_rd"}, wmem_rd_out, 0);
    check({tag, "_addr"}, wmem_addr_out, 0);
    check({tag, "_wdata"}, weight_data_out, 0);
    check({tag, "_wvalid"}, weight_valid_out, 0);
    check({tag, "_done"}, done_out, 0);
    check({tag, "_err"}, err_out, 0);
  endtask

  // Runs one job from an idle negedge to the idle negedge after it ends.
  // abort_widx >= 0 aborts while that weight is presented; rst_drain withholds
  // the last activation and resets the DUT once all weights are taken.
  task automatic run_job(input int iters, input int reads, input int wbase,
                         input int stall_first, input int abort_widx,
                         input bit rand_bp, input bit rst_drain);
    int widx, ridx, acts, total, act_limit, stall, pend_addr, k;
    bit zero, pend, exp_done, finished;
    logic [AW-1:0] a;
    zero      = (iters == 0) || (reads == 0);
    total     = iters * reads;
    act_limit = rst_drain ? total - 1 : total;
    widx = 0; ridx = 0; acts = 0; stall = stall_first; pend = 0; pend_addr = 0;
    finished = 0; exp_wstall = 0; exp_cycles = 0; k = 1;
    exp_done = zero;

    check("idle_avail", job_avail_out, 1);
    job_valid_in     = 1'b1;
    job_num_iters_in = LI'(iters);
    job_num_reads_in = LR'(reads);
    job_wbase_in     = AW'(wbase);
    // Stray activation transfer and abort while idle must both be ignored.
    act_valid_mon_in = 1'b1;
    act_avail_mon_in = 1'b1;
    abort_in         = 1'b1;
    weight_avail_in  = 1'b1;
    wmem_data_in     = DW'($urandom);

    while (!finished && k <= Budget) begin
      @(negedge clk);
      if (k == 1) begin
        job_valid_in     = 1'b0;
        job_num_iters_in = LI'($urandom);
        job_num_reads_in = LR'($urandom);
        job_wbase_in     = AW'($urandom);
        abort_in         = 1'b0;
        check("latched_iters", disp_num_iters_out, iters);
        check("latched_reads", disp_num_reads_per_iter_out, reads);
      end
      exp_cycles++;
      check("done", done_out, exp_done);
      check("err", err_out, zero);
      check("busy", job_avail_out, 0);
      check("configure", disp_configure_out, (k == 1) && !zero);
      if (exp_done) begin
        finished = 1;
      end else begin
        if (rst_drain && (widx == iters)) begin
          #2 rst = 1'b0;
          #1 check_reset_outputs("drain_rst");
          act_valid_mon_in = 1'b1;
          act_avail_mon_in = 1'b1;
          @(negedge clk);
          rst = 1'b1;
          repeat (2) @(negedge clk);
          check_reset_outputs("post_rst");
          act_valid_mon_in = 1'b0;
          act_avail_mon_in = 1'b0;
          return;
        end
        if (wmem_rd_out) begin
          a = AW'(wbase + ridx);
          check("rd_addr", wmem_addr_out, a);
          check("one_outstanding", ridx, widx);
          ridx++;
        end
        wmem_data_in = pend ? mem[pend_addr] : DW'($urandom);
        pend         = wmem_rd_out;
        pend_addr    = int'(wmem_addr_out);
        if (weight_valid_out) begin
          a = AW'(wbase + widx);
          check("wdata", weight_data_out, mem[a]);
          check("wcount", widx < iters, 1);
          if (abort_widx >= 0 && widx == abort_widx) begin
            abort_in        = 1'b1;
            weight_avail_in = 1'b1;
            @(negedge clk);
            abort_in         = 1'b0;
            act_valid_mon_in = 1'b0;
            act_avail_mon_in = 1'b0;
            check("abort_wvalid", weight_valid_out, 0);
            check("abort_idle", job_avail_out, 1);
            check("abort_done", done_out, 0);
            repeat (3) begin
              @(negedge clk);
              check("abort_quiet", done_out, 0);
            end
            return;
          end
          if (stall > 0) begin
            weight_avail_in = 1'b0;
            stall--;
          end else begin
            weight_avail_in = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
          end
          if (!weight_avail_in) exp_wstall++;
          if (weight_avail_in) widx++;
        end else begin
          weight_avail_in = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        act_valid_mon_in = 1'($urandom_range(0, 1));
        act_avail_mon_in = (acts < act_limit) ? 1'($urandom_range(0, 1)) : 1'b0;
        if (act_valid_mon_in && act_avail_mon_in) acts++;
        exp_done = (widx == iters) && (acts == total);
      end
      k++;
    end

    check("job_finished", finished, 1);
    check("n_reads", ridx, zero ? 0 : iters);
    check("n_weights", widx, zero ? 0 : iters);
    act_valid_mon_in = 1'b0;
    act_avail_mon_in = 1'b0;
    weight_avail_in  = 1'b1;
    @(negedge clk);
    check("idle_after", job_avail_out, 1);
    check("done_once", done_out, 0);
    check("err_sticky", err_out, zero);
`ifdef DISPATCHER_SEQ_PERF_EN
    check("perf_wstall", perf_wstall_out, exp_wstall);
    check("perf_cycles", perf_job_cycles_out, exp_cycles);
`endif
  endtask

  initial begin
    rst              = 1'b0;
    job_valid_in     = 1'b0;
    job_num_iters_in = '0;
    job_num_reads_in = '0;
    job_wbase_in     = '0;
    abort_in         = 1'b0;
    wmem_data_in     = '0;
    weight_avail_in  = 1'b0;
    act_valid_mon_in = 1'b0;
    act_avail_mon_in = 1'b0;
    for (int i = 0; i < int'(MemWords); i++) mem[i] = DW'($urandom);
    mem[16] = 8'd1;
    mem[17] = 8'd2;

    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b1;
    @(negedge clk);

    run_job(2, 4, 16, 0, -1, 1'b0, 1'b0);    // basic
    run_job(2, 4, 16, 5, -1, 1'b0, 1'b0);    // weight backpressure
    run_job(0, 4, 100, 0, -1, 1'b0, 1'b0);   // zero iterations
    repeat (2) begin
      @(negedge clk);
      check("err_hold", err_out, 1);
    end
    run_job(3, 0, 200, 0, -1, 1'b0, 1'b0);   // zero reads
    run_job(2, 4, 1023, 0, -1, 1'b0, 1'b0);  // address wrap
    run_job(3, 2, 40, 0, 1, 1'b0, 1'b0);     // abort in iteration 1
    run_job(1, 1, 50, 0, -1, 1'b0, 1'b0);
    run_job(1, 4, 60, 0, -1, 1'b0, 1'b1);    // reset in drain
    run_job(1, 1, 70, 0, -1, 1'b0, 1'b0);
    repeat (12) begin
      run_job($urandom_range(1, 5), $urandom_range(1, 4), $urandom_range(0, 1023),
              $urandom_range(0, 3), -1, 1'b1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
